// File: rtl/mmul_nxn.sv
// N x N signed fixed-point matrix multiplier built around one shared MAC.
// Optional build macro MMUL_NXN_SAT_EN clamps out-of-range elements instead of wrapping.
module mmul_nxn #(
  parameter int N  = 2,
  parameter int IW = 8,
  parameter int FW = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_rdy,
  input  logic [N*N*(IW+FW)-1:0]      a_flat,
  input  logic [N*N*(IW+FW)-1:0]      b_flat,
  output logic [N*N*(IW+FW)-1:0]      res_flat,
  output logic                        busy,
  output logic                        out_rdy,
  output logic                        ovf
);

  localparam int W     = IW + FW;
  localparam int ACC_W = 2*W + $clog2(N);
  localparam int IDX_W = $clog2(N);

  typedef enum logic {IDLE, MAC} state_t;

  state_t state_q, state_d;

  logic signed [W-1:0] a_q   [N][N];
  logic signed [W-1:0] a_d   [N][N];
  logic signed [W-1:0] b_q   [N][N];
  logic signed [W-1:0] b_d   [N][N];
  logic signed [W-1:0] res_q [N][N];
  logic signed [W-1:0] res_d [N][N];

  logic [IDX_W-1:0] i_q, i_d, j_q, j_d, k_q, k_d;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    ovf_q, ovf_d;

  logic signed [2*W-1:0]   prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] t;
  logic [ACC_W-W:0]        t_hi;
  logic                    el_ovf;
  logic [W-1:0]            elem;

  logic k_last, j_last, i_last;

  // One product per cycle; sign-extended so the accumulator never wraps.
  assign prod     = (2*W)'(a_q[i_q][k_q]) * (2*W)'(b_q[k_q][j_q]);
  assign prod_ext = ACC_W'(prod);
  assign sum      = acc_q + prod_ext;
  assign t        = sum >>> FW;

  // In range only when every bit above the element's sign bit copies it.
  assign t_hi   = t[ACC_W-1:W-1];
  assign el_ovf = !((&t_hi) || !(|t_hi));

`ifdef MMUL_NXN_SAT_EN
  assign elem = el_ovf ? (t[ACC_W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}})
                       : t[W-1:0];
`else
  assign elem = t[W-1:0];
`endif

  assign k_last = (k_q == IDX_W'(N-1));
  assign j_last = (j_q == IDX_W'(N-1));
  assign i_last = (i_q == IDX_W'(N-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          a_q[r][c]   <= '0;
          b_q[r][c]   <= '0;
          res_q[r][c] <= '0;
        end
      end
      i_q    <= '0;
      j_q    <= '0;
      k_q    <= '0;
      acc_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    acc_d   = acc_q;
    busy_d  = busy_q;
    done_d  = done_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (in_rdy) begin
          for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
              a_d[r][c] = a_flat[(r*N+c)*W +: W];
              b_d[r][c] = b_flat[(r*N+c)*W +: W];
            end
          end
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          acc_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = MAC;
        end
      end

      MAC: begin
        if (!k_last) begin
          acc_d = sum;
          k_d   = k_q + IDX_W'(1);
        end else begin
          // Dot product complete: commit the element and step row-major.
          res_d[i_q][j_q] = elem;
          ovf_d           = ovf_q | el_ovf;
          acc_d           = '0;
          k_d             = '0;
          if (j_last) begin
            j_d = '0;
            if (i_last) begin
              i_d     = '0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              i_d = i_q + IDX_W'(1);
            end
          end else begin
            j_d = j_q + IDX_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      assign res_flat[(r*N+c)*W +: W] = res_q[r][c];
    end
  end

  assign busy    = busy_q;
  assign out_rdy = done_q;
  assign ovf     = ovf_q;

endmodule

// File: doc/mmul_nxn.md
Name: mmul_nxn

Overview:
- Parametrised successor of the fixed 2x2 matrix multiplier: computes C = A x B for square N x N matrices of signed two's-complement fixed-point elements (IW integer bits, FW fraction bits).
- Single shared multiply-accumulate (MAC) datapath, one product per cycle.
- Full-precision accumulation with correct carry propagation, then rescale to the input Q format.
- Sits behind the same start/done handshake as the existing matrix block.

Parameters:
- N, 2, matrix dimension (N >= 2).
- IW, 8, integer bits per element, sign included.
- FW, 8, fraction bits per element.
- Derived (localparams, not overridable):
  - W = IW+FW, element width.
  - ACC_W = 2*W + $clog2(N), accumulator width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_rdy  in  1  start request; sampled only when idle.
- a_flat  in  N*N*W  matrix A; element (r,c) at bits [(r*N+c)*W +: W].
- b_flat  in  N*N*W  matrix B; same packing as a_flat.
- res_flat  out  N*N*W  result C; same packing as a_flat.
- busy  out  1  high while a multiplication is in progress.
- out_rdy  out  1  result valid; held until the next accepted start.
- ovf  out  1  sticky per operation; set if any element exceeded W-bit range.

Behaviour:
- Reset (async, any time, including mid-operation):
  - res_flat=0, busy=0, out_rdy=0, ovf=0.
  - Internal operand copies, accumulator and indices cleared; FSM goes to IDLE.
  - No partial result survives reset.
- FSM states: IDLE, MAC.
  - IDLE, in_rdy=1 at an edge (capture edge E0):
    - Latch a_flat/b_flat into internal registers.
    - Clear out_rdy and ovf; busy<=1.
    - i=j=k=0, acc=0; go to MAC.
  - IDLE, in_rdy=0: hold all outputs.
  - MAC, each edge:
    - p = A[i][k]*B[k][j], signed, 2W bits, sign-extended to ACC_W.
    - k<N-1: acc<=acc+p, k++.
    - k==N-1: s = acc+p; write element (i,j) of res_flat = rescale(s); acc<=0; k<=0; advance j, then i (row-major).
    - After writing element (N-1,N-1): busy<=0, out_rdy<=1, go to IDLE.
- Latency: out_rdy rises at edge E0+N^3 (N=2: 8 cycles).
- res_flat elements update progressively during MAC. They are valid only while out_rdy=1.
- in_rdy while busy: ignored, not queued.
- in_rdy at the same edge out_rdy would rise: ignored, because the FSM is still in MAC.
- in_rdy held high in IDLE: a new operation starts every N^3+1 cycles.
- Inputs may change freely after E0; operands are latched at E0.
- rescale(s):
  - t = s >>> FW (arithmetic shift, floor toward -inf).
  - Overflow if t is outside [-2^(W-1), 2^(W-1)-1]; any overflow sets ovf.
  - Handling of an out-of-range t is per the optional feature.
- No rounding. The accumulator never overflows: ACC_W is sized for worst case.

Optional Feature:
- Macro: MMUL_NXN_SAT_EN.
- Defined: out-of-range t clamps to 2^(W-1)-1 (positive) or -2^(W-1) (negative).
- Undefined: element = t[W-1:0] (wrap).
- ovf is set identically in both builds.

Test Plan (defaults N=2, Q8.8; each line is stimulus -> required response):
- Identity: A=I (0x0100 on diagonal), B={0x0180,0x0200,0xFF00,0x0040} -> res=B; out_rdy rises exactly 8 cycles after capture edge; busy high for those 8 cycles; ovf=0.
- Signed and floor: A=all 0xFF00 (-1.0), B=all 0x0080 (0.5) -> every element 0xFF00 (-1.0). Separately, A[0][0]=0xFFFF, B[0][0]=0x0001, rest 0 -> C[0][0]=0xFFFF (floor of -2^-16), all other elements 0.
- Overflow: A=all 0x7F00 (127.0), B=all 0x7F00 -> ovf=1; elements 0x7FFF with MMUL_NXN_SAT_EN, wrapped low 16 bits without it. Then a clean operation -> ovf returns to 0.
- Handshake: pulse in_rdy during busy (cycle 3) -> ignored, result unchanged. Hold in_rdy high continuously -> back-to-back operations; out_rdy low on each capture edge, high 8 cycles later; operands changed after E0 do not affect the result.
- Reset mid-operation: assert rst at cycle 4 of MAC -> all outputs 0 immediately (async). Restart after release -> correct result, 8-cycle latency.
- Parametric: N=3 with A=all-ones (0x0100), B=I -> all elements 0x0100; out_rdy rises 27 cycles after capture.
